// File: rtl/fb_pkg.sv
// Shared constants and encodings for the framebuffer write arbiter.
package fb_pkg;

  localparam int         FB_ADDR_W     = 14;
  localparam int         FB_DATA_W     = 8;
  localparam int         FB_WORDS_DEF  = 2400;
  localparam logic [7:0] FB_CLEAR_DATA = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant (bit0=A, bit1=B), remembers the last winner.
module rr_arb2
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_a,
  input  logic       req_b,
  output logic [1:0] gnt
);

  gnt_e last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      // On a tie the requester that did not win last time goes first.
      if (req_a && (!req_b || (last_q == GNT_B))) begin
        gnt    = 2'b01;
        last_d = GNT_A;
      end else if (req_b) begin
        gnt    = 2'b10;
        last_d = GNT_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the VGA text-framebuffer write port between the core (A) and the console (B),
// and owns a clear engine that fills every cell with CLEAR_DATA.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                ADDR_W     = FB_ADDR_W,
  parameter int                DATA_W     = FB_DATA_W,
  parameter int                FB_WORDS   = FB_WORDS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_DATA = FB_CLEAR_DATA
) (
  input  logic              clk48,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] vga_waddr,
  output logic [DATA_W-1:0] vga_wdata,
  output logic              vga_wr_en
);

  // Handshake: a write transfers in any cycle where valid && ready. Requesters keep
  // addr/data/valid stable until accepted; ready is combinational and at most one is high.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W + 1)'(FB_WORDS);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;

  logic       arb_en;
  logic [1:0] gnt;
  logic       a_in_range;
  logic       b_in_range;

  assign arb_en     = (state_q == IDLE) && !clr_start;
  assign a_in_range = {1'b0, a_addr} < WORDS_EXT;
  assign b_in_range = {1'b0, b_addr} < WORDS_EXT;

  rr_arb2 u_arb (
    .clk   (clk48),
    .rst   (rst),
    .en    (arb_en),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt   (gnt)
  );

  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = done_q;
  assign vga_waddr = waddr_q;
  assign vga_wdata = wdata_q;
  assign vga_wr_en = wr_en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (gnt[0]) begin
          // Out-of-range writes are accepted but never reach the framebuffer.
          if (a_in_range) begin
            waddr_d = a_addr;
            wdata_d = a_data;
            wr_en_d = 1'b1;
          end
        end else if (gnt[1]) begin
          if (b_in_range) begin
            waddr_d = b_addr;
            wdata_d = b_data;
            wr_en_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        waddr_d = cnt_q;
        wdata_d = CLEAR_DATA;
        wr_en_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a cycle-level behavioural model.
module tb_fb_write_arbiter;

  localparam int         AW    = 14;
  localparam int         DW    = 8;
  localparam int         WORDS = 2400;
  localparam logic [7:0] FILL  = 8'h20;

  // ---------------- clock / reset ----------------
  logic          clk48 = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] vga_waddr;
  logic [DW-1:0] vga_wdata;
  logic          vga_wr_en;

  always #10 clk48 = ~clk48;

  fb_write_arbiter dut (
    .clk48     (clk48),
    .rst       (rst),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .vga_waddr (vga_waddr),
    .vga_wdata (vga_wdata),
    .vga_wr_en (vga_wr_en)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [AW+DW-1:0] exp_q[$];

  // Reference model: clear progress as a plain index, tie-break as "whose turn it is".
  bit m_clearing = 1'b0;
  int m_idx      = 0;
  bit m_a_turn   = 1'b1;

  // Requester state: a pending write is held until the model grants it.
  bit            a_pend = 1'b0, b_pend = 1'b0;
  logic [AW-1:0] a_addr_r = '0, b_addr_r = '0;
  logic [DW-1:0] a_data_r = '0, b_data_r = '0;
  int            a_rate = 0, b_rate = 0;
  int            wr_cnt = 0, done_cnt = 0;
  bit            a_acc_seen = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic gen_addr(output logic [AW-1:0] ad);
    if ($urandom_range(9) == 0) ad = AW'($urandom_range(2**AW - 1, WORDS));
    else                        ad = AW'($urandom_range(WORDS - 1));
  endtask

  task automatic cycle(input bit clr, input bit r);
    bit               ga, gb, nwr, ndone;
    logic [AW+DW-1:0] word;
    if (!a_pend && ($urandom_range(99) < a_rate)) begin
      a_pend = 1'b1; gen_addr(a_addr_r); a_data_r = DW'($urandom);
    end
    if (!b_pend && ($urandom_range(99) < b_rate)) begin
      b_pend = 1'b1; gen_addr(b_addr_r); b_data_r = DW'($urandom);
    end
    a_valid = a_pend; a_addr = a_addr_r; a_data = a_data_r;
    b_valid = b_pend; b_addr = b_addr_r; b_data = b_data_r;
    clr_start = clr;
    rst = r;
    #1;
    ga = 1'b0; gb = 1'b0; nwr = 1'b0; ndone = 1'b0; word = '0;
    if (r) begin
      m_clearing = 1'b0; m_idx = 0; m_a_turn = 1'b1;
      exp_q.delete();
    end else begin
      check_eq("clr_busy", clr_busy, m_clearing);
      if (m_clearing) begin
        nwr  = 1'b1;
        word = {AW'(m_idx), FILL};
        if (m_idx == WORDS - 1) begin
          ndone = 1'b1;
          m_clearing = 1'b0;
        end
        m_idx++;
      end else if (clr) begin
        m_clearing = 1'b1;
        m_idx = 0;
      end else begin
        ga = a_pend && (!b_pend || m_a_turn);
        gb = b_pend && !ga;
        if (ga) begin
          m_a_turn = 1'b0;
          if (a_addr_r < WORDS) begin nwr = 1'b1; word = {a_addr_r, a_data_r}; end
        end
        if (gb) begin
          m_a_turn = 1'b1;
          if (b_addr_r < WORDS) begin nwr = 1'b1; word = {b_addr_r, b_data_r}; end
        end
      end
      check_eq("a_ready", a_ready, ga);
      check_eq("b_ready", b_ready, gb);
    end
    if (nwr) exp_q.push_back(word);
    @(posedge clk48);
    @(negedge clk48);
    check_eq("vga_wr_en", vga_wr_en, nwr);
    check_eq("clr_done", clr_done, ndone);
    if (vga_wr_en === 1'b1) wr_cnt++;
    if (clr_done === 1'b1) done_cnt++;
    if (nwr && exp_q.size() > 0) begin
      word = exp_q.pop_front();
      check_eq("vga_waddr", vga_waddr, word[AW+DW-1:DW]);
      check_eq("vga_wdata", vga_wdata, word[DW-1:0]);
    end
    if (ga) a_pend = 1'b0;
    if (gb) b_pend = 1'b0;
    a_acc_seen = ga;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk48);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check_eq("rst_wr_en", vga_wr_en, 1'b0);
    check_eq("rst_waddr", vga_waddr, 0);
    check_eq("rst_wdata", vga_wdata, 0);
    check_eq("rst_busy", clr_busy, 1'b0);
    check_eq("rst_done", clr_done, 1'b0);

    // Single A write.
    a_pend = 1'b1; a_addr_r = 14'h005; a_data_r = 8'h41;
    cycle(1'b0, 1'b0);
    check_eq("dir_a_waddr", vga_waddr, 14'h005);
    check_eq("dir_a_wdata", vga_wdata, 8'h41);
    check_eq("dir_a_wr_en", vga_wr_en, 1'b1);

    // Both requesters continuously valid: alternating grants.
    a_rate = 100; b_rate = 100;
    repeat (4) cycle(1'b0, 1'b0);
    a_rate = 0; b_rate = 0;
    repeat (2) cycle(1'b0, 1'b0);

    // Out-of-range B write is accepted and dropped.
    b_pend = 1'b1; b_addr_r = 14'h2000; b_data_r = 8'h77;
    cycle(1'b0, 1'b0);
    check_eq("oor_wr_en", vga_wr_en, 1'b0);

    // Full clear with A stalled, plus a second clr_start that must be ignored.
    a_pend = 1'b1; a_addr_r = 14'h010; a_data_r = 8'h55;
    wr_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < WORDS + 50 && m_clearing; i++) cycle(i == 100, 1'b0);
    check_eq("clr_timeout", m_clearing, 1'b0);
    check_eq("clr_writes", wr_cnt, WORDS);
    check_eq("clr_done_cnt", done_cnt, 1);
    check_eq("clr_last_addr", vga_waddr, WORDS - 1);
    cycle(1'b0, 1'b0);
    check_eq("post_clr_a_acc", a_acc_seen, 1'b1);

    // Reset in the middle of a clear.
    done_cnt = 0;
    cycle(1'b1, 1'b0);
    repeat (500) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_eq("abort_busy", clr_busy, 1'b0);
    check_eq("abort_wr_en", vga_wr_en, 1'b0);
    a_pend = 1'b1; a_addr_r = 14'h007; a_data_r = 8'h42;
    cycle(1'b0, 1'b0);
    check_eq("abort_done_cnt", done_cnt, 0);
    check_eq("abort_a_waddr", vga_waddr, 14'h007);

    // Random traffic with occasional clears.
    a_rate = 50; b_rate = 50;
    for (int i = 0; i < 600; i++) cycle($urandom_range(299) == 0, 1'b0);
    a_rate = 0; b_rate = 0;
    for (int i = 0; i < WORDS + 10 && (m_clearing || a_pend || b_pend); i++) cycle(1'b0, 1'b0);
    check_eq("drain_done", m_clearing || a_pend || b_pend, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Shares the single VGA text-framebuffer write port (vga_waddr/vga_wdata/vga_wr_en) between two requesters: A is the core store path and B is the console/UART echo path. It also contains a built-in clear engine that sweeps the whole framebuffer with a fill character. It sits between the core and vgadisplay in fpga_root and runs on the 48 MHz system clock.

Parameters:
ADDR_W, 14, framebuffer address width.
DATA_W, 8, character/attribute data width.
FB_WORDS, 2400, number of valid framebuffer cells (80x30); must be <= 2**ADDR_W.
CLEAR_DATA, 8'h20, fill value written by the clear engine (ASCII space).

Ports:
clk48  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
a_addr  in  ADDR_W  requester A write address.
a_data  in  DATA_W  requester A write data.
a_valid  in  1  requester A has a write pending.
a_ready  out  1  requester A write accepted this cycle.
b_addr  in  ADDR_W  requester B write address.
b_data  in  DATA_W  requester B write data.
b_valid  in  1  requester B has a write pending.
b_ready  out  1  requester B write accepted this cycle.
clr_start  in  1  single-cycle pulse that starts a full-screen clear.
clr_busy  out  1  clear in progress.
clr_done  out  1  single-cycle pulse after the last clear write.
vga_waddr  out  ADDR_W  framebuffer write address (registered).
vga_wdata  out  DATA_W  framebuffer write data (registered).
vga_wr_en  out  1  framebuffer write strobe (registered).

Behaviour:
- Reset values: vga_wr_en=0, vga_waddr=0, vga_wdata=0, clr_busy=0, clr_done=0, state=IDLE, clear counter=0, last_grant=B (so A wins the first tie).
- Handshake: valid/ready. A transfer occurs when valid&&ready. Requesters hold addr/data/valid stable until accepted. a_ready and b_ready are combinational from the valid signals, state, clr_start and last_grant. At most one ready is high per cycle.
- IDLE arbitration:
  - If clr_start=1: neither ready is asserted; next state is CLEAR.
  - Else, if only one requester is valid, that requester is granted.
  - Else, if both are valid, the requester not in last_grant is granted (round-robin), and last_grant updates on each grant.
  - With no valid input, last_grant holds.
- Latency: an accepted write appears on vga_* exactly 1 cycle later with vga_wr_en=1 for one cycle. Back-to-back grants give one write per cycle.
- Out-of-range address (addr >= FB_WORDS): the write is accepted (ready=1) and dropped (vga_wr_en stays 0 next cycle).
- CLEAR state:
  - a_ready=b_ready=0 and clr_busy=1.
  - Writes CLEAR_DATA to addresses 0..FB_WORDS-1, one per cycle, so vga_wr_en is high for FB_WORDS consecutive cycles.
  - After the FB_WORDS-1 write is issued, the block returns to IDLE and clr_done pulses in the cycle that write appears on vga_*.
  - clr_start during CLEAR is ignored (no restart, no queued second clear).
- Total clear time: FB_WORDS cycles of busy, and the first requester grant is possible in the cycle after clr_busy falls.
- Reset mid-clear aborts immediately: counter clears, no clr_done, vga_wr_en=0 next cycle.
- Pending requester valids are never lost, only stalled.
- Counter width is ADDR_W. It never wraps because it terminates at FB_WORDS-1.

Decomposition:
- Package fb_pkg:
  - ADDR_W/DATA_W defaults, FB_WORDS, CLEAR_DATA.
  - State enum {IDLE, CLEAR}.
  - Grant encoding {GNT_A, GNT_B}.
- One sub-module is natural: rr_arb2, a 2-way round-robin arbiter (valids in, one-hot grant out, last_grant register with enable). The clear engine stays inline.

Test Plan:
- Reset, then a_valid with addr=0x005 and data=0x41 -> a_ready=1 same cycle; next cycle vga_wr_en=1, vga_waddr=0x005, vga_wdata=0x41.
- a_valid and b_valid held high for 4 cycles -> grants A,B,A,B; vga_wr_en high on 4 consecutive cycles with alternating data.
- clr_start pulse with a_valid high -> a_ready=0; vga_wr_en high for 2400 cycles, addresses 0..2399, data 0x20; clr_done pulses with addr 2399; a_ready=1 the cycle after clr_busy falls.
- b_valid with addr=0x2000 (>=2400) -> b_ready=1, vga_wr_en stays 0.
- Second clr_start at clear cycle 100 -> ignored; exactly 2400 writes and one clr_done.
- rst asserted at clear cycle 500 -> clr_busy=0 and vga_wr_en=0 next cycle, no clr_done; then a normal A write succeeds.
